// File: rtl/psum_acc_if.sv
// psum_acc_if: beat input and result output handshake bundle of the partial-sum accumulator
interface psum_acc_if #(
    parameter int C_DIN  = 13,
    parameter int C_DOUT = 16
);
    logic [C_DIN-1:0]  din;
    logic              din_vld;
    logic              first;
    logic              last;
    logic              din_rdy;
    logic [C_DOUT-1:0] dout;
    logic              dout_sat;
    logic              dout_vld;
    logic              dout_rdy;

    modport slave (
        input  din, din_vld, first, last, dout_rdy,
        output din_rdy, dout, dout_sat, dout_vld
    );

    modport master (
        output din, din_vld, first, last, dout_rdy,
        input  din_rdy, dout, dout_sat, dout_vld
    );
endinterface

// File: rtl/psum_acc.sv
// psum_acc: windowed signed accumulator with output saturation and a 2-entry result FIFO
module psum_acc #(
    parameter int C_DIN  = 13,
    parameter int C_ACC  = 24,
    parameter int C_DOUT = 16
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    psum_acc_if.slave   bus,
    output logic        O_err
);
    typedef enum logic {IDLE, ACC} state_t;

    localparam logic signed [C_ACC-1:0] SAT_MAX = {{(C_ACC-C_DOUT+1){1'b0}}, {(C_DOUT-1){1'b1}}};
    localparam logic signed [C_ACC-1:0] SAT_MIN = ~SAT_MAX;

    state_t                  state_q, state_d;
    logic signed [C_ACC-1:0] acc_q, acc_d, sx;
    logic                    err_q, err_d;
    logic [C_DOUT:0]         mem_q [2];
    logic                    rd_q, wr_q, rdy_q;
    logic [1:0]              cnt_q, cnt_d;
    logic                    accept, restart, push, pop, sat;
    logic [C_DOUT-1:0]       res;

    assign accept  = bus.din_vld & rdy_q;
    assign sx      = C_ACC'($signed(bus.din));
    assign restart = bus.first | (state_q == IDLE);
    assign push    = accept & bus.last;
    assign pop     = (cnt_q != 2'd0) & bus.dout_rdy;

    // Next accumulator/state/error and the saturated result of the current beat
    always_comb begin
        acc_d   = accept ? (restart ? sx : acc_q + sx) : acc_q;
        state_d = accept ? (bus.last ? IDLE : ACC) : state_q;
        err_d   = err_q | (accept & (bus.first == (state_q == ACC)));
        sat     = (acc_d > SAT_MAX) | (acc_d < SAT_MIN);
        res     = acc_d > SAT_MAX ? SAT_MAX[C_DOUT-1:0] :
                  acc_d < SAT_MIN ? SAT_MIN[C_DOUT-1:0] : acc_d[C_DOUT-1:0];
        cnt_d   = cnt_q + 2'(push) - 2'(pop);
    end

    // Window FSM: accumulator, framing state and sticky error
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

    // Result FIFO; input ready is registered from the post-edge occupancy
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            mem_q <= '{default: '0};
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
            rdy_q <= 1'b0;
        end else begin
            if (push) mem_q[wr_q] <= {sat, res};
            wr_q  <= wr_q ^ push;
            rd_q  <= rd_q ^ pop;
            cnt_q <= cnt_d;
            rdy_q <= cnt_d != 2'd2;
        end
    end

    assign bus.din_rdy                = rdy_q;
    assign {bus.dout_sat, bus.dout}   = mem_q[rd_q];
    assign bus.dout_vld               = cnt_q != 2'd0;
    assign O_err                      = err_q;
endmodule

// File: tb/tb_psum_acc.sv
// tb_psum_acc: random and directed windows against a queue-based reference model, 16- and 12-bit outputs
module tb_psum_acc;
    localparam int C_DIN = 13;
    localparam int C_ACC = 24;

    typedef struct {
        bit     sat;
        longint v;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [C_DIN-1:0] din = '0;
    logic             vld = 1'b0, first = 1'b0, last = 1'b0, drdy = 1'b0;
    logic             err16, err12;

    always #5 clk = ~clk;

    psum_acc_if #(.C_DIN(C_DIN), .C_DOUT(16)) b16 ();
    psum_acc_if #(.C_DIN(C_DIN), .C_DOUT(12)) b12 ();

    assign b16.din = din;
    assign b16.din_vld = vld;
    assign b16.first = first;
    assign b16.last = last;
    assign b16.dout_rdy = drdy;
    assign b12.din = din;
    assign b12.din_vld = vld;
    assign b12.first = first;
    assign b12.last = last;
    assign b12.dout_rdy = drdy;

    psum_acc #(.C_DIN(C_DIN), .C_ACC(C_ACC), .C_DOUT(16)) dut16 (
        .I_clk(clk), .I_rst_n(rst_n), .bus(b16.slave), .O_err(err16)
    );
    psum_acc #(.C_DIN(C_DIN), .C_ACC(C_ACC), .C_DOUT(12)) dut12 (
        .I_clk(clk), .I_rst_n(rst_n), .bus(b12.slave), .O_err(err12)
    );

    res_t   q16[$], q12[$];
    int     n_chk = 0, n_err = 0;
    bit     m_in_win, m_err, m_rdy, m_zero, m_known, accepted;
    longint m_acc;

    task automatic check(string tag, longint got, longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint wrap(longint v, int w);
        longint m = longint'(1) << w;
        v = v % m;
        if (v < 0) v += m;
        if (v >= m / 2) v -= m;
        return v;
    endfunction

    function automatic res_t satr(longint v, int w);
        longint hi = (longint'(1) << (w - 1)) - 1;
        res_t r;
        r.sat = (v > hi) || (v < -hi - 1);
        r.v = v > hi ? hi : (v < -hi - 1 ? -hi - 1 : v);
        return r;
    endfunction

    task automatic chk_q(string tag, input res_t q[$], longint dout, bit sat, bit dvld);
        check({tag, ".vld"}, longint'(dvld), longint'(q.size() != 0));
        if (q.size() != 0) begin
            check({tag, ".dout"}, dout, q[0].v);
            check({tag, ".sat"}, longint'(sat), longint'(q[0].sat));
        end else if (m_zero) begin
            check({tag, ".dout0"}, dout, 0);
            check({tag, ".sat0"}, longint'(sat), 0);
        end
    endtask

    // One clock: compare outputs before the edge, then advance the model across it
    task automatic cycle();
        longint sx;
        @(negedge clk);
        if (m_known) begin
            chk_q("d16", q16, longint'($signed(b16.dout)), b16.dout_sat, b16.dout_vld);
            chk_q("d12", q12, longint'($signed(b12.dout)), b12.dout_sat, b12.dout_vld);
            check("rdy16", longint'(b16.din_rdy), longint'(m_rdy));
            check("rdy12", longint'(b12.din_rdy), longint'(m_rdy));
            check("err16", longint'(err16), longint'(m_err));
            check("err12", longint'(err12), longint'(m_err));
        end
        accepted = 1'b0;
        if (!rst_n) begin
            q16.delete();
            q12.delete();
            m_in_win = 0;
            m_acc = 0;
            m_err = 0;
            m_rdy = 0;
            m_zero = 1;
            m_known = 1;
        end else if (m_known) begin
            if (drdy && q16.size() != 0) begin
                void'(q16.pop_front());
                void'(q12.pop_front());
            end
            if (vld && m_rdy) begin
                accepted = 1'b1;
                sx = longint'($signed(din));
                if (!m_in_win || first) begin
                    if (m_in_win == first) m_err = 1;
                    m_acc = sx;
                end else begin
                    m_acc = wrap(m_acc + sx, C_ACC);
                end
                if (last) begin
                    q16.push_back(satr(m_acc, 16));
                    q12.push_back(satr(m_acc, 12));
                    m_zero = 0;
                    m_in_win = 0;
                end else begin
                    m_in_win = 1;
                end
            end
            m_rdy = q16.size() != 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(longint d, bit f, bit l);
        din = C_DIN'(d);
        first = f;
        last = l;
        vld = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) cycle();
        if (!accepted) check("send_timeout", 0, 1);
        vld = 1'b0;
    endtask

    task automatic idle(int n);
        vld = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        int r;
        // Reset held for three cycles, then release
        rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        idle(2);
        // Basic window 5 - 3 + 100
        drdy = 1'b1;
        send(5, 1, 0);
        send(-3, 0, 0);
        send(100, 0, 1);
        idle(3);
        // Saturation boundaries
        repeat (3) send(4095, 0, 0) ;
        send(4095, 0, 1);
        send(4095, 1, 0);
        repeat (2) send(4095, 0, 0);
        send(4095, 0, 1);
        send(2047, 1, 0);
        repeat (2) send(2047, 0, 0);
        send(2047, 0, 1);
        send(-2048, 1, 0);
        repeat (2) send(-2048, 0, 0);
        send(-2048, 0, 1);
        idle(4);
        // Backpressure: third single-beat window stalls until a slot frees
        drdy = 1'b0;
        send(1, 1, 1);
        send(2, 1, 1);
        din = C_DIN'(3);
        first = 1'b1;
        last = 1'b1;
        vld = 1'b1;
        repeat (3) cycle();
        drdy = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) cycle();
        if (!accepted) check("bp_timeout", 0, 1);
        idle(5);
        // Framing errors
        send(7, 0, 0);
        send(9, 0, 1);
        send(4, 1, 0);
        send(6, 1, 0);
        send(1, 0, 1);
        idle(3);
        // Reset in the middle of a window
        send(10, 1, 0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        idle(1);
        send(3, 1, 1);
        idle(3);
        // Long window wrapping the accumulator
        send(4095, 1, 0);
        repeat (2100) send(4095, 0, 0);
        send(4095, 0, 1);
        idle(3);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = $urandom_range(0, 399) != 0;
            vld = $urandom_range(0, 9) < 7;
            drdy = $urandom_range(0, 9) < 6;
            r = int'($urandom_range(0, 9));
            din = r < 2 ? 13'd4095 : r < 4 ? 13'h1000 : C_DIN'($urandom_range(0, 8191));
            first = m_in_win ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 19) != 0);
            last = $urandom_range(0, 4) == 0;
            cycle();
        end
        rst_n = 1'b1;
        drdy = 1'b1;
        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
